ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//   Shares the single data port of the data RAM (0x1000-0x118F data region,
//   stack region, 0x1200 UART register) between two requesters:
//   - CPU load/store unit
//   - UART-to-RAM loader (DMA)
//   Fixed CPU priority with a bounded hold window, so neither side starves.
//   Drives the RAM's MemWrite/A/WriteData; returns registered read data.
// PARAMETERS
//   AW        32  address width
//   DW        32  data width
//   MAX_HOLD  8   max consecutive grants to one owner while the other waits (>=1)
// PORTS
//   clk         in   1   clock; all state updates on posedge
//   rst_n       in   1   reset, asynchronous, active-low
//   cpu_req     in   1   CPU access request; held until cpu_gnt
//   cpu_we      in   1   1=write, 0=read
//   cpu_addr    in   AW  byte address (word aligned)
//   cpu_wdata   in   DW  write data
//   cpu_gnt     out  1   access accepted this cycle
//   cpu_rdata   out  DW  read data, valid when cpu_rvalid
//   cpu_rvalid  out  1   one-cycle pulse, cycle after a read grant
//   dma_req, dma_we, dma_addr, dma_wdata  in   same as cpu_*
//   dma_gnt, dma_rdata, dma_rvalid        out  same as cpu_*
//   ram_we      out  1   to RAM MemWrite
//   ram_addr    out  AW  to RAM A
//   ram_wdata   out  DW  to RAM WriteData
//   ram_rdata   in   DW  from RAM ReadData (combinational read)
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     - State = IDLE, hold_cnt = 0.
//     - All gnt/rvalid/ram_we = 0; rdata/ram_addr/ram_wdata = 0.
//     - An in-flight access is dropped and no rvalid follows.
//   States:
//     - IDLE -> CPU if cpu_req, else DMA if dma_req, else stay.
//     - Any IDLE transition costs 1 cycle; no grant is issued in IDLE.
//   State CPU (DMA is symmetric):
//     - cpu_gnt = cpu_req (combinational).
//     - On each gnt edge: hold_cnt += 1.
//     - If gnt && hold_cnt==MAX_HOLD-1 && dma_req: next = DMA, hold_cnt = 0.
//     - If !cpu_req: next = DMA if dma_req, else IDLE; hold_cnt = 0.
//       This cycle issues no grant (1 bubble).
//     - If the other side is not requesting, hold_cnt saturates at
//       MAX_HOLD-1 and the owner keeps the port.
//   RAM side:
//     - ram_addr/ram_wdata mux the owner's inputs; they are 0 in IDLE.
//     - ram_we = owner_gnt & owner_we; never asserts without a grant.
//   Reads:
//     - On a read grant, ram_rdata is registered into owner rdata at that edge.
//     - owner rvalid = 1 for exactly the next cycle.
//     - The other side's rdata holds its last value.
//   Writes: complete in the grant cycle; no rvalid.
//   Requester rules:
//     - addr/we/wdata stable while req=1 and gnt=0.
//     - req may stay high for back-to-back accesses, one per grant cycle.
//   Simultaneous req in IDLE: CPU wins.
//   Mutual exclusion: cpu_gnt and dma_gnt are never both 1.
//   rvalid is never both 1 either.
// TESTING
//   1. Reset: rst_n=0 mid-grant -> all outputs 0 same cycle; after release,
//      IDLE, no stray rvalid.
//   2. CPU read 0x1004, RAM returns 0xDEADBEEF -> IDLE 1 cycle, cpu_gnt=1,
//      ram_addr=0x1004, ram_we=0; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
//   3. CPU and DMA both req in IDLE -> CPU granted first; DMA waits.
//   4. CPU streams writes, dma_req held high -> exactly 8 cpu_gnt, then
//      dma_gnt from the next cycle; at most 8 dma_gnt, then back to CPU.
//   5. DMA write 0x1010=0x55 alone -> ram_we=1 one cycle, ram_wdata=0x55;
//      dma_req drop -> IDLE, ram_we=0.
//   6. Assertions over random traffic:
//      - never both gnt;
//      - ram_we implies a grant;
//      - every read gnt is followed by exactly one rvalid.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Single requester port of the RAM arbiter: request/write payload in, grant and
// registered read data back. The requester uses master, the arbiter uses slave.
interface ram_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic [DW-1:0] rdata;
    logic          rvalid;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdata, rvalid
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the data RAM port between the CPU load/store unit and the UART loader DMA.
// CPU has fixed priority, but a hold window of MAX_HOLD grants bounds either side's tenure.
module ram_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_port_arbiter_if.slave   cpu,
    ram_port_arbiter_if.slave   dma,
    output logic                ram_we,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_DMA  = 2'd2
    } state_t;

    localparam int            HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    state_t        state, state_next;
    logic [HW-1:0] hold_cnt, hold_next;

    logic          cpu_gnt, dma_gnt;
    logic          cpu_rvalid_q, dma_rvalid_q;
    logic [DW-1:0] cpu_rdata_q, dma_rdata_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
        end
    end

    // hold_cnt counts grants already given to the current owner; it saturates
    // while the other side is quiet so a late request is served on the next grant.
    // NOTE: defaults at the top of every always_comb keep it free of inferred latches.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        unique case (state)
            S_IDLE: begin
                hold_next = '0;
                if (cpu.req)      state_next = S_CPU;
                else if (dma.req) state_next = S_DMA;
            end
            S_CPU: begin
                if (!cpu.req) begin
                    hold_next  = '0;
                    state_next = dma.req ? S_DMA : S_IDLE;
                end else if (hold_cnt == HOLD_MAX) begin
                    if (dma.req) begin
                        hold_next  = '0;
                        state_next = S_DMA;
                    end
                end else begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            S_DMA: begin
                if (!dma.req) begin
                    hold_next  = '0;
                    state_next = cpu.req ? S_CPU : S_IDLE;
                end else if (hold_cnt == HOLD_MAX) begin
                    if (cpu.req) begin
                        hold_next  = '0;
                        state_next = S_CPU;
                    end
                end else begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            default: begin
                hold_next  = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (state)
            S_CPU: begin
                cpu_gnt   = cpu.req;
                ram_we    = cpu.req & cpu.we;
                ram_addr  = cpu.addr;
                ram_wdata = cpu.wdata;
            end
            S_DMA: begin
                dma_gnt   = dma.req;
                ram_we    = dma.req & dma.we;
                ram_addr  = dma.addr;
                ram_wdata = dma.wdata;
            end
            default: ;
        endcase
    end

    // The RAM reads combinationally, so read data is captured at the grant edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= cpu_gnt & ~cpu.we;
            dma_rvalid_q <= dma_gnt & ~dma.we;
            if (cpu_gnt && !cpu.we) cpu_rdata_q <= ram_rdata;
            if (dma_gnt && !dma.we) dma_rdata_q <= ram_rdata;
        end
    end

    assign cpu.gnt    = cpu_gnt;
    assign cpu.rvalid = cpu_rvalid_q;
    assign cpu.rdata  = cpu_rdata_q;
    assign dma.gnt    = dma_gnt;
    assign dma.rvalid = dma_rvalid_q;
    assign dma.rdata  = dma_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and constrained-random bench for ram_port_arbiter with a small word RAM
// model on the shared port; inputs change 2 time units after posedge, checks 1 unit later.
module tb_ram_port_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) cpu_if ();
    ram_port_arbiter_if #(.AW(AW), .DW(DW)) dma_if ();

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (cpu_if),
        .dma       (dma_if),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // RAM model: 256 words at 0x1000, combinational read, write on posedge.
    logic [31:0] mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)      mem[pre_idx] <= pre_data;
        else if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr[9:2]];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_idx  = a[9:2];
        pre_data = d;
        cyc();
        pre_we   = 1'b0;
    endtask

    task automatic idle_reqs();
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        dma_if.req = 1'b0; dma_if.we = 1'b0; dma_if.addr = '0; dma_if.wdata = '0;
    endtask

    logic        g_cpu, g_dma, exp_cpu, exp_dma;
    logic        exp_rv_cpu, exp_rv_dma, last_gc, last_gd;
    logic [31:0] exp_rd_cpu, exp_rd_dma;
    int          wait_cpu, wait_dma, max_wait;

    initial begin
        rst_n  = 1'b0;
        pre_we = 1'b0;
        idle_reqs();
        #3;
        check("rst_cpu_gnt", cpu_if.gnt, 0);
        check("rst_dma_gnt", dma_if.gnt, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_cpu_rvalid", cpu_if.rvalid, 0);
        preload(32'h1004, 32'hDEADBEEF);
        preload(32'h1008, 32'h11112222);
        preload(32'h100C, 32'h33334444);
        @(negedge clk);
        rst_n = 1'b1;

        // CPU single read: one IDLE cycle, grant, then rvalid
        cyc();
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'h1004;
        #1;
        check("t2_idle_nogrant", cpu_if.gnt, 0);
        cyc(); #1;
        check("t2_cpu_gnt", cpu_if.gnt, 1);
        check("t2_dma_gnt", dma_if.gnt, 0);
        check("t2_ram_addr", ram_addr, 32'h1004);
        check("t2_ram_we", ram_we, 0);
        cyc();
        cpu_if.req = 1'b0;
        #1;
        check("t2_rvalid", cpu_if.rvalid, 1);
        check("t2_rdata", cpu_if.rdata, 32'hDEADBEEF);
        check("t2_bubble", cpu_if.gnt, 0);
        cyc(); #1;
        check("t2_rvalid_pulse", cpu_if.rvalid, 0);
        check("t2_idle_addr", ram_addr, 0);

        // Simultaneous requests: CPU first, DMA after the bubble
        cyc();
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'h1008;
        dma_if.req = 1'b1; dma_if.we = 1'b0; dma_if.addr = 32'h100C;
        #1;
        check("t3_idle_cpu", cpu_if.gnt, 0);
        check("t3_idle_dma", dma_if.gnt, 0);
        cyc(); #1;
        check("t3_cpu_first", cpu_if.gnt, 1);
        check("t3_dma_waits", dma_if.gnt, 0);
        cyc();
        cpu_if.req = 1'b0;
        #1;
        check("t3_cpu_rvalid", cpu_if.rvalid, 1);
        check("t3_cpu_rdata", cpu_if.rdata, 32'h11112222);
        check("t3_bubble_dma", dma_if.gnt, 0);
        cyc(); #1;
        check("t3_dma_gnt", dma_if.gnt, 1);
        check("t3_cpu_gnt", cpu_if.gnt, 0);
        check("t3_dma_addr", ram_addr, 32'h100C);
        cyc();
        dma_if.req = 1'b0;
        #1;
        check("t3_dma_rvalid", dma_if.rvalid, 1);
        check("t3_dma_rdata", dma_if.rdata, 32'h33334444);
        check("t3_cpu_rvalid_off", cpu_if.rvalid, 0);
        check("t3_cpu_rdata_hold", cpu_if.rdata, 32'h11112222);
        cyc(); #1;
        check("t3_dma_rvalid_pulse", dma_if.rvalid, 0);

        // Both stream writes: alternating windows of MAX_HOLD grants
        cyc();
        cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 32'h1040; cpu_if.wdata = 32'hC000_0000;
        dma_if.req = 1'b1; dma_if.we = 1'b1; dma_if.addr = 32'h1080; dma_if.wdata = 32'hD000_0000;
        #1;
        for (int i = 0; i < 3 * MAX_HOLD + 2; i++) begin
            exp_cpu = (i != 0) && (((i - 1) / MAX_HOLD) % 2 == 0);
            exp_dma = (i != 0) && (((i - 1) / MAX_HOLD) % 2 == 1);
            check($sformatf("t4_cpu_gnt_%0d", i), cpu_if.gnt, exp_cpu);
            check($sformatf("t4_dma_gnt_%0d", i), dma_if.gnt, exp_dma);
            check($sformatf("t4_ram_we_%0d", i), ram_we, exp_cpu | exp_dma);
            g_cpu = cpu_if.gnt;
            g_dma = dma_if.gnt;
            cyc();
            if (g_cpu) begin cpu_if.addr += 4; cpu_if.wdata += 1; end
            if (g_dma) begin dma_if.addr += 4; dma_if.wdata += 1; end
            #1;
        end
        cyc();
        idle_reqs();
        #1;
        cyc(); #1;
        check("t4_back_idle", cpu_if.gnt | dma_if.gnt, 0);
        check("t4_mem_cpu_first", mem[8'h10], 32'hC000_0000);
        check("t4_mem_cpu_last", mem[8'h17], 32'hC000_0007);
        check("t4_mem_dma_last", mem[8'h27], 32'hD000_0007);

        // Lone DMA write
        cyc();
        dma_if.req = 1'b1; dma_if.we = 1'b1; dma_if.addr = 32'h1010; dma_if.wdata = 32'h55;
        #1;
        check("t5_idle_we", ram_we, 0);
        cyc(); #1;
        check("t5_dma_gnt", dma_if.gnt, 1);
        check("t5_ram_we", ram_we, 1);
        check("t5_ram_wdata", ram_wdata, 32'h55);
        check("t5_ram_addr", ram_addr, 32'h1010);
        cyc();
        dma_if.req = 1'b0;
        #1;
        check("t5_we_drop", ram_we, 0);
        check("t5_no_rvalid", dma_if.rvalid, 0);
        check("t5_mem", mem[8'h04], 32'h55);
        cyc(); #1;
        check("t5_idle_addr", ram_addr, 0);

        // Reset in the middle of a read grant
        cyc();
        cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 32'h1004;
        #1;
        cyc(); #1;
        check("t1_pre_gnt", cpu_if.gnt, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t1_gnt", cpu_if.gnt, 0);
        check("t1_ram_addr", ram_addr, 0);
        check("t1_ram_we", ram_we, 0);
        check("t1_cpu_rdata", cpu_if.rdata, 0);
        check("t1_dma_rdata", dma_if.rdata, 0);
        check("t1_cpu_rvalid", cpu_if.rvalid, 0);
        cyc();
        cyc();
        #3;
        rst_n = 1'b1;
        #1;
        check("t1_rel_idle", cpu_if.gnt, 0);
        check("t1_rel_rvalid", cpu_if.rvalid, 0);
        cyc(); #1;
        check("t1_no_stray_rvalid", cpu_if.rvalid, 0);
        check("t1_regrant", cpu_if.gnt, 1);
        cyc();
        cpu_if.req = 1'b0;
        #1;
        check("t1_rvalid", cpu_if.rvalid, 1);
        check("t1_rdata", cpu_if.rdata, 32'hDEADBEEF);
        cyc();
        cyc();

        // Random traffic against a per-cycle protocol model
        exp_rv_cpu = 1'b0; exp_rv_dma = 1'b0;
        exp_rd_cpu = '0;   exp_rd_dma = '0;
        last_gc = 1'b0;    last_gd = 1'b0;
        wait_cpu = 0; wait_dma = 0; max_wait = 0;
        for (int n = 0; n < 600; n++) begin
            cyc();
            if (!cpu_if.req || last_gc) begin
                cpu_if.req   = ($urandom_range(0, 3) != 0);
                cpu_if.we    = 1'($urandom_range(0, 1));
                cpu_if.addr  = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
                cpu_if.wdata = $urandom;
            end
            if (!dma_if.req || last_gd) begin
                dma_if.req   = ($urandom_range(0, 3) != 0);
                dma_if.we    = 1'($urandom_range(0, 1));
                dma_if.addr  = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
                dma_if.wdata = $urandom;
            end
            #1;
            check("r_gnt_mutex", cpu_if.gnt & dma_if.gnt, 0);
            check("r_rvalid_mutex", cpu_if.rvalid & dma_if.rvalid, 0);
            check("r_we_needs_gnt", ram_we & ~(cpu_if.gnt | dma_if.gnt), 0);
            check("r_cpu_rvalid", cpu_if.rvalid, exp_rv_cpu);
            check("r_dma_rvalid", dma_if.rvalid, exp_rv_dma);
            if (exp_rv_cpu) check("r_cpu_rdata", cpu_if.rdata, exp_rd_cpu);
            if (exp_rv_dma) check("r_dma_rdata", dma_if.rdata, exp_rd_dma);
            if (cpu_if.gnt) check("r_cpu_addr", ram_addr, cpu_if.addr);
            if (dma_if.gnt) check("r_dma_addr", ram_addr, dma_if.addr);
            if (cpu_if.gnt) check("r_cpu_we", ram_we, cpu_if.we);
            if (dma_if.gnt) check("r_dma_we", ram_we, dma_if.we);
            exp_rv_cpu = cpu_if.gnt & ~cpu_if.we;
            exp_rv_dma = dma_if.gnt & ~dma_if.we;
            if (exp_rv_cpu) exp_rd_cpu = mem[cpu_if.addr[9:2]];
            if (exp_rv_dma) exp_rd_dma = mem[dma_if.addr[9:2]];
            wait_cpu = (cpu_if.req && !cpu_if.gnt) ? wait_cpu + 1 : 0;
            wait_dma = (dma_if.req && !dma_if.gnt) ? wait_dma + 1 : 0;
            if (wait_cpu > max_wait) max_wait = wait_cpu;
            if (wait_dma > max_wait) max_wait = wait_dma;
            last_gc = cpu_if.gnt;
            last_gd = dma_if.gnt;
        end
        check("r_max_wait_bounded", 32'(max_wait <= MAX_HOLD + 4), 1);
        cyc();
        idle_reqs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
